// File: rtl/fft_frame_sequencer_pkg.sv
// Shared definitions for the FFT frame sequencer.
// Default sizes and FSM state encodings.
package fft_frame_sequencer_pkg;

  localparam int N_DEF  = 512;
  localparam int L_DEF  = 9;
  localparam int DW_DEF = 16;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_START   = 3'd2;
  localparam logic [2:0] S_COMPUTE = 3'd3;
  localparam logic [2:0] S_DRAIN   = 3'd4;

endpackage

// File: rtl/fft_frame_sequencer_out_fifo2.sv
// fft_out_fifo2: 2-entry FIFO with occupancy count.
// Ports: clk, rst, push/push_data, pop, head_data, count.
module fft_out_fifo2 #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head_data,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         wptr;
  logic         rptr;

  assign head_data = mem[rptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wptr   <= 1'b0;
      rptr   <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wptr] <= push_data;
        wptr      <= ~wptr;
      end
      if (pop) begin
        rptr <= ~rptr;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fft_frame_sequencer.sv
// Frame controller for the in-place radix-2 FFT.
// Ports: in_* load stream, ram_* data RAM, initial_flag/fft_finish, out_* result stream, busy.
module fft_frame_sequencer
  import fft_frame_sequencer_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int L_MAX = L_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_re,
  input  logic [DW-1:0]    in_im,
  output logic             ram_wr_en,
  output logic [L_MAX-1:0] ram_wr_addr,
  output logic [DW-1:0]    ram_wr_re,
  output logic [DW-1:0]    ram_wr_im,
  output logic             ram_rd_en,
  output logic [L_MAX-1:0] ram_rd_addr,
  input  logic [DW-1:0]    ram_rd_re,
  input  logic [DW-1:0]    ram_rd_im,
  output logic             initial_flag,
  input  logic             fft_finish,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_re,
  output logic [DW-1:0]    out_im,
  output logic             out_last,
  output logic             busy
);

  localparam int CW = L_MAX + 1;
  localparam logic [CW-1:0] C_LAST = CW'(N - 1);
  localparam logic [CW-1:0] C_N    = CW'(N);

  logic [2:0]       state;
  logic [CW-1:0]    in_cnt;
  logic [CW-1:0]    rd_cnt;
  logic [L_MAX-1:0] rev;
  logic             accept;
  logic             pop;
  logic             rd_issue;
  logic             rd_inflight;
  logic             rd_last_inflight;
  logic [1:0]       fifo_count;
  logic [2:0]       occ;
  logic [2*DW:0]    head;

  for (genvar i = 0; i < L_MAX; i++) begin : g_rev
    assign rev[i] = in_cnt[L_MAX-1-i];
  end

  assign in_ready = (state == S_IDLE) ||
                    (state == S_LOAD);
  assign accept       = in_valid & in_ready;
  assign busy         = (state != S_IDLE);
  assign initial_flag = (state == S_START);

  // Credit counts the slot freed by a same-cycle pop,
  // so a full-rate stream never bubbles.
  assign occ = {1'b0, fifo_count}
             + {2'b0, rd_inflight}
             - {2'b0, pop};
  assign rd_issue = (state == S_DRAIN) &&
                    (rd_cnt < C_N) &&
                    (occ < 3'd2);

  assign ram_rd_en   = rd_issue;
  assign ram_rd_addr = rd_issue ?
                       rd_cnt[L_MAX-1:0] : '0;

  assign out_valid = (fifo_count != 2'd0);
  assign pop       = out_valid & out_ready;
  assign out_last  = out_valid & head[2*DW];
  assign out_re    = out_valid ?
                     head[2*DW-1:DW] : '0;
  assign out_im    = out_valid ?
                     head[DW-1:0] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      in_cnt <= '0;
      rd_cnt <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            state  <= S_LOAD;
            in_cnt <= CW'(1);
          end
        end
        S_LOAD: begin
          if (accept) begin
            if (in_cnt == C_LAST) begin
              state  <= S_START;
              in_cnt <= '0;
            end else begin
              in_cnt <= in_cnt + CW'(1);
            end
          end
        end
        S_START: begin
          state <= S_COMPUTE;
        end
        S_COMPUTE: begin
          if (fft_finish) begin
            state  <= S_DRAIN;
            rd_cnt <= '0;
          end
        end
        S_DRAIN: begin
          if (rd_issue) begin
            rd_cnt <= rd_cnt + CW'(1);
          end
          if (pop && head[2*DW]) begin
            state  <= S_IDLE;
            rd_cnt <= '0;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_wr_en   <= 1'b0;
      ram_wr_addr <= '0;
      ram_wr_re   <= '0;
      ram_wr_im   <= '0;
    end else begin
      ram_wr_en   <= accept;
      ram_wr_addr <= accept ? rev : '0;
      ram_wr_re   <= accept ? in_re : '0;
      ram_wr_im   <= accept ? in_im : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_inflight      <= 1'b0;
      rd_last_inflight <= 1'b0;
    end else begin
      rd_inflight      <= rd_issue;
      rd_last_inflight <= rd_issue &&
                          (rd_cnt == C_LAST);
    end
  end

  fft_out_fifo2 #(
    .W (2*DW+1)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rd_inflight),
    .push_data ({rd_last_inflight,
                 ram_rd_re, ram_rd_im}),
    .pop       (pop),
    .head_data (head),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Bench for fft_frame_sequencer.
// Randomized frames against a queue/array reference.
module tb_fft_frame_sequencer;

  localparam int N  = 512;
  localparam int L  = 9;
  localparam int DW = 16;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_re;
  logic [DW-1:0] in_im;
  logic          ram_wr_en;
  logic [L-1:0]  ram_wr_addr;
  logic [DW-1:0] ram_wr_re;
  logic [DW-1:0] ram_wr_im;
  logic          ram_rd_en;
  logic [L-1:0]  ram_rd_addr;
  logic [DW-1:0] ram_rd_re;
  logic [DW-1:0] ram_rd_im;
  logic          initial_flag;
  logic          fft_finish;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_re;
  logic [DW-1:0] out_im;
  logic          out_last;
  logic          busy;

  fft_frame_sequencer #(
    .N (N), .L_MAX (L), .DW (DW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_re        (in_re),
    .in_im        (in_im),
    .ram_wr_en    (ram_wr_en),
    .ram_wr_addr  (ram_wr_addr),
    .ram_wr_re    (ram_wr_re),
    .ram_wr_im    (ram_wr_im),
    .ram_rd_en    (ram_rd_en),
    .ram_rd_addr  (ram_rd_addr),
    .ram_rd_re    (ram_rd_re),
    .ram_rd_im    (ram_rd_im),
    .initial_flag (initial_flag),
    .fft_finish   (fft_finish),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_re       (out_re),
    .out_im       (out_im),
    .out_last     (out_last),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h",
               tag, got, exp);
    end
  endtask

  function automatic int brev(input int k);
    int r = 0;
    for (int b = 0; b < L; b++)
      r = r * 2 + ((k >> b) & 1);
    return r;
  endfunction

  int            q_addr[$];
  logic [DW-1:0] q_re[$];
  logic [DW-1:0] q_im[$];
  int            wr_pulses;
  int            flag_pulses;
  int            wr1_addr;
  int            wa;
  logic [DW-1:0] img_re [N];
  logic [DW-1:0] img_im [N];
  int            out_idx;
  int            rd_idx;
  int            popped;
  int            first_pop;
  int            last_pop;
  int            occ;
  bit            pop_now;
  bit            rnd_ready;

  // RAM model: data valid the cycle after a read,
  // junk otherwise.
  always @(posedge clk) begin
    if (ram_rd_en) begin
      ram_rd_re <= img_re[ram_rd_addr];
      ram_rd_im <= img_im[ram_rd_addr];
    end else begin
      ram_rd_re <= 16'hbad0;
      ram_rd_im <= 16'h0bad;
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rnd_ready ?
                  1'($urandom_range(1)) : 1'b1;
    end
  end

  // Write-side scoreboard
  always @(negedge clk) begin
    if (!rst && ram_wr_en) begin
      if (q_addr.size() == 0) begin
        chk("wr_extra", 1, 0);
      end else begin
        wa = q_addr.pop_front();
        chk("wr_addr", ram_wr_addr, wa);
        chk("wr_re", ram_wr_re, q_re.pop_front());
        chk("wr_im", ram_wr_im, q_im.pop_front());
      end
      if (wr_pulses == 1) wr1_addr = ram_wr_addr;
      wr_pulses++;
    end
    if (!rst && initial_flag) flag_pulses++;
  end

  // Read/output scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      pop_now = out_valid && out_ready;
      occ = rd_idx - popped;
      if (ram_rd_en) begin
        chk("rd_addr", ram_rd_addr, rd_idx);
        chk("rd_credit",
            (occ + 1 - int'(pop_now)) <= 2, 1);
        rd_idx++;
      end
      if (pop_now) begin
        if (out_idx >= N) begin
          chk("out_extra", 1, 0);
        end else begin
          chk("out_re", out_re, img_re[out_idx]);
          chk("out_im", out_im, img_im[out_idx]);
          chk("out_last", out_last,
              out_idx == N - 1);
          if (out_idx == 0) first_pop = cyc;
          last_pop = cyc;
        end
        out_idx++;
        popped++;
      end
    end
  end

  task automatic load_beats(input int n,
                            input bit ramp,
                            input bit spur);
    int  k = 0;
    int  stall = 0;
    bit  acc;
    while (k < n) begin
      in_valid = ($urandom_range(3) != 0);
      if (ramp) begin
        in_re = 16'(k);
        in_im = 16'(-k);
      end else begin
        in_re = 16'($urandom);
        in_im = 16'($urandom);
      end
      fft_finish = spur &&
                   ($urandom_range(7) == 0);
      @(negedge clk);
      chk("ld_ready", in_ready, 1);
      chk("ld_flag", initial_flag, 0);
      acc = in_valid && in_ready;
      if (!in_ready) stall++;
      if (stall > 50) begin
        chk("ld_timeout", 1, 0);
        break;
      end
      if (acc) begin
        q_addr.push_back(brev(k));
        q_re.push_back(in_re);
        q_im.push_back(in_im);
      end
      @(posedge clk);
      #1;
      if (acc) k++;
    end
    in_valid   = 1'b0;
    fft_finish = 1'b0;
  endtask

  task automatic run_frame(input bit ramp,
                           input bit spur,
                           input bit rr,
                           input bit img_ramp);
    int e_cyc;
    wr_pulses   = 0;
    flag_pulses = 0;
    rd_idx      = 0;
    popped      = 0;
    out_idx     = 0;
    chk("pre_busy", busy, 0);
    chk("pre_ready", in_ready, 1);
    load_beats(N, ramp, spur);
    chk("start_flag", initial_flag, 1);
    chk("start_ready", in_ready, 0);
    chk("start_wr", ram_wr_en, 1);
    @(posedge clk);
    #1;
    chk("wr_pulses", wr_pulses, N);
    chk("flag_pulses", flag_pulses, 1);
    chk("wr_q_empty", q_addr.size(), 0);
    if (ramp) chk("wr1_addr", wr1_addr, 256);
    chk("comp_flag", initial_flag, 0);
    for (int i = 0; i < N; i++) begin
      img_re[i] = img_ramp ? 16'(i) :
                  16'($urandom);
      img_im[i] = img_ramp ? 16'(2 * i) :
                  16'($urandom);
    end
    repeat ($urandom_range(10, 2)) begin
      in_valid = 1'b1;
      in_re    = 16'($urandom);
      chk("comp_ready", in_ready, 0);
      chk("comp_ram",
          {ram_wr_en, ram_rd_en,
           ram_wr_addr, ram_rd_addr}, 0);
      @(posedge clk);
      #1;
    end
    rnd_ready  = rr;
    fft_finish = 1'b1;
    @(posedge clk);
    #1;
    fft_finish = 1'b0;
    e_cyc = cyc;
    chk("drain_rd_en", ram_rd_en, 1);
    chk("drain_addr0", ram_rd_addr, 0);
    for (int t = 0; t < 5000 && out_idx < N; t++)
    begin
      chk("drain_ready", in_ready, 0);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (out_idx < N)
      chk("drain_timeout", out_idx, N);
    chk("post_busy", busy, 0);
    chk("post_ready", in_ready, 1);
    chk("rd_total", rd_idx, N);
    if (!rr) begin
      chk("first_lat", first_pop - e_cyc, 2);
      chk("stream_len",
          last_pop - first_pop, N - 1);
    end
    rnd_ready = 1'b0;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_wr"},
        {ram_wr_en, ram_wr_addr,
         ram_wr_re, ram_wr_im}, 0);
    chk({tag, "_rd"},
        {ram_rd_en, ram_rd_addr,
         initial_flag, busy}, 0);
    chk({tag, "_out"},
        {out_valid, out_re, out_im,
         out_last}, 0);
    chk({tag, "_ready"}, in_ready, 1);
  endtask

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_re      = '0;
    in_im      = '0;
    fft_finish = 1'b0;
    rnd_ready  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outs("rst0");
    rst = 1'b0;
    @(posedge clk);
    #1;
    fft_finish = 1'b1;
    @(posedge clk);
    #1;
    fft_finish = 1'b0;
    chk("idle_spur_busy", busy, 0);
    chk("idle_spur_rd", ram_rd_en, 0);

    run_frame(1'b1, 1'b1, 1'b0, 1'b1);
    run_frame(1'b0, 1'b0, 1'b1, 1'b1);
    run_frame(1'b0, 1'b0, 1'b0, 1'b0);

    wr_pulses = 0;
    load_beats(100, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outs("rst1");
    chk("rst_wr_q", q_addr.size(), 0);
    chk("rst_wr_cnt", wr_pulses, 100);
    q_addr.delete();
    q_re.delete();
    q_im.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    run_frame(1'b1, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d",
             checks, errors);
    $finish;
  end

endmodule
